// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

  localparam int PC_WIDTH    = 64;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    FAULT
  } state_t;

endpackage

// File: rtl/fetch_controller.sv
// Fetch sequencer for the 64-byte synchronous instruction memory: owns the fetch
// pointer, tracks the one-cycle read latency and presents instructions with PC/valid.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [PC_WIDTH-1:0] LAST_PC  = 64'd44
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                halt_req,
  input  logic [31:0]         imem_instruction,
  output logic [PC_WIDTH-1:0] pc,
  output logic                instr_valid,
  output logic [31:0]         instruction,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic [15:0]         instr_count,
  output logic                busy,
  output logic                done,
  output logic                fault
);

  state_t              state;
  logic [PC_WIDTH-1:0] fpc;
  logic [PC_WIDTH-1:0] pc_q;
  logic                vld;

  logic hold;
  logic consume;
  logic redirect_bad;

  assign hold         = vld & stall;
  assign consume      = vld & ~stall;
  assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc > LAST_PC);

  // Re-presenting the held address keeps the memory output stable while stalled.
  assign pc          = hold ? pc_q : fpc;
  assign instruction = imem_instruction;
  assign instr_pc    = pc_q;
  assign instr_valid = vld;
  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign fault       = (state == FAULT);

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fpc         <= RESET_PC;
      pc_q        <= '0;
      vld         <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            fpc         <= RESET_PC;
            vld         <= 1'b0;
            instr_count <= '0;
          end
        end

        RUN: begin
          if (halt_req) begin
            state <= DONE;
            vld   <= 1'b0;
          end else if (redirect_valid) begin
            vld <= 1'b0;
            if (consume) instr_count <= instr_count + 16'd1;
            if (redirect_bad) state <= FAULT;
            else              fpc   <= redirect_pc;
          end else if (hold) begin
            // Consumer not ready: everything stays put.
          end else if (fpc <= LAST_PC) begin
            pc_q <= fpc;
            vld  <= 1'b1;
            fpc  <= fpc + PC_WIDTH'(INSTR_BYTES);
            if (consume) instr_count <= instr_count + 16'd1;
          end else begin
            // Past the last word and not holding: any presented word is consumed now.
            vld   <= 1'b0;
            state <= DONE;
            if (consume) instr_count <= instr_count + 16'd1;
          end
        end

        FAULT: vld <= 1'b0;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller with a synchronous 16-word ROM model.
module tb_fetch_controller;
  import fetch_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                stall;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                halt_req;
  logic [31:0]         imem_instruction;
  logic [PC_WIDTH-1:0] pc;
  logic                instr_valid;
  logic [31:0]         instruction;
  logic [PC_WIDTH-1:0] instr_pc;
  logic [15:0]         instr_count;
  logic                busy;
  logic                done;
  logic                fault;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] rom [16];

  fetch_controller dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halt_req         (halt_req),
    .imem_instruction (imem_instruction),
    .pc               (pc),
    .instr_valid      (instr_valid),
    .instruction      (instruction),
    .instr_pc         (instr_pc),
    .instr_count      (instr_count),
    .busy             (busy),
    .done             (done),
    .fault            (fault)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: one-cycle read latency.
  always @(posedge clk) imem_instruction <= rom[pc[5:2]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rom[0]  = 32'h00500093;
    rom[1]  = 32'h00A00113;
    rom[2]  = 32'h021101B3;
    rom[3]  = 32'h00102023;
    rom[4]  = 32'h00302283;
    rom[5]  = 32'h40208333;
    rom[6]  = 32'h0062F3B3;
    rom[7]  = 32'h00116413;
    rom[8]  = 32'h007404B3;
    rom[9]  = 32'hFFF48513;
    rom[10] = 32'h00A02223;
    rom[11] = 32'h00000073;
    for (int i = 12; i < 16; i++) rom[i] = 32'hDEAD0000 | 32'(i);

    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    halt_req = 1'b0;

    // Reset state
    #12;
    check("rst_pc", pc, 64'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_instr_pc", instr_pc, 64'h0);
    check("rst_count", instr_count, 16'd0);
    check("rst_flags", {busy, done, fault}, 3'b000);
    step();
    rst_n = 1'b1;
    step();
    check("idle_flags", {busy, done, fault}, 3'b000);

    // Full run without stalls: 0..44 back to back, then DONE with 12 consumed
    do_start();
    check("start_busy", busy, 1'b1);
    check("start_valid", instr_valid, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("run_valid_%0d", i), instr_valid, 1'b1);
      check($sformatf("run_pc_%0d", i), instr_pc, 64'(4 * i));
      check($sformatf("run_instr_%0d", i), instruction, rom[i]);
      if (i == 2) check("run_instr_pc8", instruction, 32'h021101B3);
    end
    step();
    check("end_done", done, 1'b1);
    check("end_valid", instr_valid, 1'b0);
    check("end_count", instr_count, 16'd12);
    step();
    check("end_stays_done", {busy, done, instr_valid}, 3'b010);

    // Stall for 3 cycles while 0x10 is presented
    do_start();
    check("restart_count", instr_count, 16'd0);
    repeat (5) step();
    check("pre_stall_pc", instr_pc, 64'h10);
    check("pre_stall_count", instr_count, 16'd4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_valid_%0d", i), instr_valid, 1'b1);
      check($sformatf("stall_pc_%0d", i), instr_pc, 64'h10);
      check($sformatf("stall_instr_%0d", i), instruction, 32'h00302283);
      check($sformatf("stall_count_%0d", i), instr_count, 16'd4);
      check($sformatf("stall_mem_pc_%0d", i), pc, 64'h10);
    end
    stall = 1'b0;
    step();
    check("post_stall_count", instr_count, 16'd5);
    check("post_stall_pc", instr_pc, 64'h14);

    // halt_req beats redirect_valid at 0x14; halted word is not counted
    halt_req = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h20;
    step();
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    check("halt_done", done, 1'b1);
    check("halt_valid", instr_valid, 1'b0);
    check("halt_count", instr_count, 16'd5);
    repeat (2) step();
    check("halt_no_issue", {instr_valid, done}, 2'b01);
    check("halt_pc_held", pc, 64'h18);

    // Restart, then redirect to 0x20 while 0x0C is presented
    do_start();
    step();
    check("restart2_pc", instr_pc, 64'h0);
    check("restart2_count", instr_count, 16'd0);
    repeat (3) step();
    check("pre_redir_pc", instr_pc, 64'h0C);
    redirect_valid = 1'b1;
    redirect_pc = 64'h20;
    step();
    redirect_valid = 1'b0;
    check("redir_bubble", instr_valid, 1'b0);
    check("redir_count", instr_count, 16'd4);
    step();
    check("redir_valid", instr_valid, 1'b1);
    check("redir_target_pc", instr_pc, 64'h20);
    check("redir_target_instr", instruction, 32'h007404B3);
    step();
    check("redir_next_pc", instr_pc, 64'h24);
    check("redir_next_instr", instruction, rom[9]);

    // Backward redirect to 0x18, then asynchronous reset mid-RUN
    redirect_valid = 1'b1;
    redirect_pc = 64'h18;
    step();
    redirect_valid = 1'b0;
    step();
    check("back_redir_pc", instr_pc, 64'h18);
    check("back_redir_valid", instr_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 64'h0);
    check("async_rst_valid", instr_valid, 1'b0);
    check("async_rst_instr_pc", instr_pc, 64'h0);
    check("async_rst_count", instr_count, 16'd0);
    check("async_rst_flags", {busy, done, fault}, 3'b000);
    step();
    rst_n = 1'b1;

    // Misaligned redirect faults; start and redirect are ignored afterwards
    do_start();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h22;
    step();
    redirect_valid = 1'b0;
    check("mis_fault", fault, 1'b1);
    check("mis_valid", instr_valid, 1'b0);
    start = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h20;
    repeat (2) step();
    start = 1'b0;
    redirect_valid = 1'b0;
    check("mis_sticky", {busy, done, fault}, 3'b001);
    check("mis_sticky_valid", instr_valid, 1'b0);

    // Out-of-range redirect faults
    rst_n = 1'b0;
    step();
    check("fault_cleared", fault, 1'b0);
    rst_n = 1'b1;
    do_start();
    repeat (2) step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h30;
    step();
    redirect_valid = 1'b0;
    check("oor_fault", fault, 1'b1);
    check("oor_valid", instr_valid, 1'b0);
    do_start();
    step();
    check("oor_start_ignored", {busy, fault, instr_valid}, 3'b010);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
